// File: rtl/sprite_addr_cal.sv
// sprite_addr_cal: per-sprite pattern-memory address generator.
// Maps the raster position to a pixel address inside one sprite's pattern and
// flags whether that position is covered by the visible sprite.
// One output register stage gives a latency of one clock.
// Optional feature: define ADDR_CAL_FLIP_EN to honour the horizontal flip bit
// (sprite_info[30]). When it is undefined, bit 30 is ignored.
module sprite_addr_cal (
    input  logic        clk,
    input  logic        reset,
    input  logic [79:0] pattern_info,
    input  logic [31:0] sprite_info,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [15:0] addr_output,
    output logic        valid
);

    logic [15:0] base;
    logic [15:0] src_w;
    logic [15:0] src_h;
    logic [15:0] disp_w;
    logic [15:0] disp_h;
    logic        visible;
    logic        flipped;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [9:0]  shift;

    assign base    = pattern_info[79:64];
    assign src_w   = pattern_info[63:48];
    assign src_h   = pattern_info[47:32];
    assign disp_w  = pattern_info[31:16];
    assign disp_h  = pattern_info[15:0];
    assign visible = sprite_info[31];
    assign flipped = sprite_info[30];
    assign pos_x   = sprite_info[29:20];
    assign pos_y   = sprite_info[19:10];
    assign shift   = sprite_info[9:0];

    // 12-bit signed offsets; a negative left edge clips at the screen edge
    logic [11:0] xs;
    logic [11:0] col;
    logic [11:0] row;
    logic [15:0] col16;
    logic [15:0] row16;
    logic [15:0] col_src;
    logic [15:0] tile_col;
    logic [15:0] tile_row;
    logic [15:0] row_base;
    logic        hit;
    logic [15:0] addr_next;

    // Hit detection and address arithmetic for the current raster position
    always_comb begin
        xs    = {2'b00, pos_x} - {2'b00, shift};
        col   = {2'b00, hcount} - xs;
        row   = {2'b00, vcount} - {2'b00, pos_y};
        col16 = {4'h0, col};
        row16 = {4'h0, row};

        // Sign bits are checked first so the unsigned compares only see
        // non-negative offsets; zero display size can never satisfy "<".
        hit = visible && !col[11] && !row[11] &&
              (col16 < disp_w) && (row16 < disp_h);

`ifdef ADDR_CAL_FLIP_EN
        col_src = flipped ? (disp_w - 16'd1 - col16) : col16;
`else
        col_src = col16;
`endif

        // Power-of-two source sizes make the mask act as a modulo, so a short
        // source tiles across a larger display area.
        tile_col  = col_src & (src_w - 16'd1);
        tile_row  = row16 & (src_h - 16'd1);
        row_base  = 16'(tile_row * src_w);
        addr_next = hit ? (base + row_base + tile_col) : '0;
    end

`ifndef ADDR_CAL_FLIP_EN
    logic unused_flip;
    assign unused_flip = flipped;
`endif

    // Output register: reset clears outputs, otherwise capture this cycle's result
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_output <= '0;
            valid       <= 1'b0;
        end else begin
            addr_output <= addr_next;
            valid       <= hit;
        end
    end

endmodule

// File: tb/tb_sprite_addr_cal.sv
// Directed testbench for sprite_addr_cal with hand-computed expected values.
module tb_sprite_addr_cal;

    logic        clk;
    logic        reset;
    logic [79:0] pattern_info;
    logic [31:0] sprite_info;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [15:0] addr_output;
    logic        valid;

    int unsigned tests_run;
    int unsigned tests_failed;

    sprite_addr_cal dut (
        .clk          (clk),
        .reset        (reset),
        .pattern_info (pattern_info),
        .sprite_info  (sprite_info),
        .hcount       (hcount),
        .vcount       (vcount),
        .addr_output  (addr_output),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] pat(input logic [15:0] b, input logic [15:0] sw,
                                        input logic [15:0] sh, input logic [15:0] dw,
                                        input logic [15:0] dh);
        return {b, sw, sh, dw, dh};
    endfunction

    function automatic logic [31:0] spr(input logic vis, input logic flp, input logic [9:0] x,
                                        input logic [9:0] y, input logic [9:0] sh);
        return {vis, flp, x, y, sh};
    endfunction

    // Drive inputs, let one rising edge pass, then check away from the edge
    task automatic step_check(input string tag, input logic [15:0] exp_addr, input logic exp_valid);
        @(posedge clk);
        #1;
        check({tag, "_addr"}, addr_output, exp_addr);
        check({tag, "_valid"}, {15'd0, valid}, {15'd0, exp_valid});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        pattern_info = pat(16'd0, 16'd32, 16'd16, 16'd32, 16'd16);
        sprite_info  = spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
        hcount       = 10'd105;
        vcount       = 10'd53;
        step_check("reset_state", 16'd0, 1'b0);
        reset = 1'b0;

        // Plain hit: c=5, r=3 -> 3*32+5
        step_check("plain_hit", 16'd101, 1'b1);

        // Flip bit: mirrored when enabled, ignored otherwise
        sprite_info = spr(1'b1, 1'b1, 10'd100, 10'd50, 10'd0);
`ifdef ADDR_CAL_FLIP_EN
        step_check("flip", 16'd122, 1'b1);
        hcount = 10'd100;
        step_check("flip_c0", 16'd127, 1'b1);
`else
        step_check("flip_ignored", 16'd101, 1'b1);
`endif

        // Tiled body: 1-row source stretched over 128 rows
        pattern_info = pat(16'd544, 16'd32, 16'd1, 16'd32, 16'd128);
        sprite_info  = spr(1'b1, 1'b0, 10'd200, 10'd100, 10'd0);
        hcount = 10'd210;
        vcount = 10'd220;
        step_check("tiled", 16'd554, 1'b1);
        vcount = 10'd227;
        step_check("tiled_last_row", 16'd554, 1'b1);
        vcount = 10'd228;
        step_check("tiled_row_eq_h", 16'd0, 1'b0);

        // Shift and left clipping
        pattern_info = pat(16'd0, 16'd32, 16'd16, 16'd32, 16'd16);
        sprite_info  = spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd20);
        hcount = 10'd80;
        vcount = 10'd50;
        step_check("shift", 16'd0, 1'b1);
        sprite_info = spr(1'b1, 1'b0, 10'd10, 10'd50, 10'd20);
        hcount = 10'd0;
        step_check("clip_left", 16'd10, 1'b1);

        // Edges and visibility around the plain-hit setup
        sprite_info = spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
        hcount = 10'd132;
        vcount = 10'd53;
        step_check("col_eq_w", 16'd0, 1'b0);
        hcount = 10'd131;
        step_check("col_last", 16'd127, 1'b1);
        hcount = 10'd99;
        step_check("col_neg1", 16'd0, 1'b0);
        hcount = 10'd105;
        vcount = 10'd65;
        step_check("row_last", 16'd485, 1'b1);
        vcount = 10'd66;
        step_check("row_eq_h", 16'd0, 1'b0);
        vcount = 10'd49;
        step_check("row_neg1", 16'd0, 1'b0);
        vcount = 10'd53;
        sprite_info = spr(1'b0, 1'b0, 10'd100, 10'd50, 10'd0);
        step_check("invisible", 16'd0, 1'b0);

        // Zero display width never hits
        sprite_info  = spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
        pattern_info = pat(16'd0, 16'd32, 16'd16, 16'd0, 16'd16);
        step_check("zero_w", 16'd0, 1'b0);

        // Base offset plus wrap of a 16-bit sum
        pattern_info = pat(16'hFFF0, 16'd32, 16'd16, 16'd32, 16'd16);
        step_check("wrap", 16'd85, 1'b1);

        // Reset mid-hit clears outputs, normal result returns after release
        pattern_info = pat(16'd0, 16'd32, 16'd16, 16'd32, 16'd16);
        step_check("pre_reset", 16'd101, 1'b1);
        reset = 1'b1;
        step_check("mid_reset", 16'd0, 1'b0);
        reset = 1'b0;
        step_check("post_reset", 16'd101, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
